shift_reg_seq: RTL and testbench
================================

SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

Interface
REQ-001 Parameter WIDTH, default 32: data register width, legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1): width of Count.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Load  input  1  parallel load of D.
REQ-006 D  input  WIDTH  parallel load data.
REQ-007 Shift_En  input  1  single-step shift request, honoured only in IDLE.
REQ-008 Start  input  1  begin a sequenced shift of Count steps.
REQ-009 Count  input  CW  number of shift steps; sampled when Start is accepted.
REQ-010 Mode  input  2  shift mode: 0 logical right, 1 arithmetic right, 2 left, 3 rotate right; sampled with Start, live for Shift_En.
REQ-011 Shift_In  input  1  serial fill bit for modes 0 and 2.
REQ-012 Shift_Out  output  1  Data_Out[0] for modes 0, 1 and 3; Data_Out[WIDTH-1] for mode 2 (combinational on the effective mode).
REQ-013 Data_Out  output  WIDTH  register contents.
REQ-014 Busy  output  1  high while the FSM is in SHIFT.
REQ-015 Done  output  1  one-cycle pulse when a sequenced shift completes.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE.
REQ-017 Priority each cycle: Reset > Load > Start > Shift_En.
REQ-018 Load in any state: Data_Out <= D, FSM -> IDLE; an in-flight sequence is aborted with no Done pulse.
REQ-019 IDLE, Start=1, Count!=0: latch Count into remaining counter and Mode into mode register; FSM -> SHIFT; no shift occurs that cycle.
REQ-020 IDLE, Start=1, Count=0: FSM -> DONE; Data_Out unchanged.
REQ-021 SHIFT: one shift per cycle using the latched mode; counter decrements; on the cycle the counter reaches 0 the FSM moves to DONE.
REQ-022 Latency: Start at edge N with Count=k (k>0) yields the final value at edge N+k and Done high for the cycle following edge N+k.
REQ-023 DONE: Done=1 for exactly one cycle; FSM -> IDLE unconditionally unless Load is asserted.
REQ-024 Start and Shift_En are ignored in SHIFT and DONE; Start is not queued.
REQ-025 IDLE, Shift_En=1, Start=0: one shift using the live Mode; FSM stays IDLE.
REQ-026 Shift rules: mode 0 {Shift_In, Data_Out[WIDTH-1:1]}; mode 1 {Data_Out[WIDTH-1], Data_Out[WIDTH-1:1]}; mode 2 {Data_Out[WIDTH-2:0], Shift_In}; mode 3 {Data_Out[0], Data_Out[WIDTH-1:1]}.
REQ-027 Count values above WIDTH are legal and perform that many shifts; no saturation.
REQ-028 Shift_In is sampled on every shift cycle of a sequence, not latched at Start.

Reset
REQ-029 Reset assertion immediately clears Data_Out to 0, counter to 0, mode register to 0, FSM to IDLE, Busy=0, Done=0.
REQ-030 Reset mid-sequence aborts the sequence with no Done pulse.
REQ-031 After deassertion the block accepts Load, Start and Shift_En on the first rising edge.

Structure
REQ-032 Package shift_pkg holds the shift_mode_e enum (SHR_LOG, SHR_ARITH, SHL, ROR) and the state_e enum (IDLE, SHIFT, DONE).
REQ-033 Shift computation is one combinational function of (data, mode, Shift_In) in shift_pkg, shared by the single-step and sequenced paths.
REQ-034 Sub-module shift_counter (CW-bit loadable down-counter with zero flag) is instantiated once; there are no other sub-modules.

Verification
REQ-035 Reset mid-SHIFT after Load 32'hDEADBEEF -> Data_Out=0, Busy=0, no Done pulse.
REQ-036 Load 32'h80000001, Start Mode=1 Count=4 -> Data_Out 32'hF8000000 after 4 cycles, Busy high for 4 cycles, Done high for 1 cycle.
REQ-037 Load 32'h0000000F, Start Mode=3 Count=36 -> Data_Out 32'hF0000000, Done after 36 shift cycles.
REQ-038 Load 32'h00000001, Shift_En Mode=2 Shift_In=1 for 3 cycles in IDLE -> 32'h0000000F, Busy stays 0.
REQ-039 Start Count=0 -> Done one cycle later, Data_Out unchanged, Busy never high.
REQ-040 Start Count=8, then Load 32'h12345678 at shift 3 -> Data_Out=32'h12345678, FSM IDLE, no Done; Start asserted during SHIFT is ignored.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and the single shift-step function for shift_reg_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  // Widest register the shared shift function supports.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    SHR_LOG   = 2'd0,
    SHR_ARITH = 2'd1,
    SHL       = 2'd2,
    ROR       = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Data arrives zero-extended to MAX_W; only the low 'width' bits are meaningful.
  function automatic logic [MAX_W-1:0] shift_step(
    input logic [MAX_W-1:0] data,
    input shift_mode_e      mode,
    input logic             fill,
    input int               width
  );
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] res;
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    top  = 64'd1 << (width - 1);
    res  = '0;
    case (mode)
      SHR_LOG:   res = (data >> 1) | (fill ? top : '0);
      SHR_ARITH: res = (data >> 1) | (((data & top) != '0) ? top : '0);
      SHL:       res = (data << 1) | {{(MAX_W-1){1'b0}}, fill};
      ROR:       res = (data >> 1) | (data[0] ? top : '0);
      default:   res = data;
    endcase
    return res & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_counter.sv
// ============================================================================
// Module      : shift_counter
// Description : Loadable down-counter with zero flag; holds at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_counter #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_seq.sv
// ============================================================================
// Module      : shift_reg_seq
// Description : Shift register with parallel load, single-step and counted shifts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CW-1:0]    Count,
  input  logic [1:0]       Mode,
  input  logic             Shift_In,
  output logic             Shift_Out,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Busy,
  output logic             Done
);

  state_e           r_state;
  state_e           w_state_next;
  shift_mode_e      r_mode;
  shift_mode_e      w_eff_mode;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    w_remaining;
  logic             w_cnt_zero;
  logic             w_seq_go;
  logic             w_seq_step;
  logic             w_idle_step;

  assign w_seq_go    = (r_state == IDLE) && !Load && Start && (Count != '0);
  assign w_seq_step  = (r_state == SHIFT) && !Load;
  assign w_idle_step = (r_state == IDLE) && !Load && !Start && Shift_En;

  // Outside IDLE the sequence mode latched at Start governs shifting and Shift_Out.
  assign w_eff_mode = (r_state == IDLE) ? shift_mode_e'(Mode) : r_mode;
  assign w_shifted  = WIDTH'(shift_step(MAX_W'(r_data), w_eff_mode, Shift_In, WIDTH));

  shift_counter #(
    .CW(CW)
  ) u_counter (
    .clk        (Clk),
    .rst        (Reset),
    .load       (w_seq_go),
    .load_value (Count),
    .dec        (w_seq_step),
    .count      (w_remaining),
    .zero       (w_cnt_zero)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (Load) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            w_state_next = (Count == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // The shift taken this cycle is the last one when one step remains.
          if (w_cnt_zero || (w_remaining == CW'(1))) begin
            w_state_next = DONE;
          end
        end
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data <= '0;
      r_mode <= SHR_LOG;
    end else begin
      if (Load) begin
        r_data <= D;
      end else if (w_seq_step || w_idle_step) begin
        r_data <= w_shifted;
      end
      if (w_seq_go) begin
        r_mode <= shift_mode_e'(Mode);
      end
    end
  end

  assign Data_Out  = r_data;
  assign Shift_Out = (w_eff_mode == SHL) ? r_data[WIDTH-1] : r_data[0];
  assign Busy      = (r_state == SHIFT);
  assign Done      = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
// ============================================================================
// Module      : tb_shift_reg_seq
// Description : Scoreboard bench for shift_reg_seq (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_seq;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic             Shift_En;
  logic             Start;
  logic [CW-1:0]    Count;
  logic [1:0]       Mode;
  logic             Shift_In;
  logic             Shift_Out;
  logic [WIDTH-1:0] Data_Out;
  logic             Busy;
  logic             Done;

  int               errors = 0;
  int               checks = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] ref_data;

  shift_reg_seq #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .D         (D),
    .Shift_En  (Shift_En),
    .Start     (Start),
    .Count     (Count),
    .Mode      (Mode),
    .Shift_In  (Shift_In),
    .Shift_Out (Shift_Out),
    .Data_Out  (Data_Out),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0] m, input logic si);
    case (m)
      2'd0:    return {si, d[WIDTH-1:1]};
      2'd1:    return {d[WIDTH-1], d[WIDTH-1:1]};
      2'd2:    return {d[WIDTH-2:0], si};
      default: return {d[0], d[WIDTH-1:1]};
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    exp_q.push_back(v);
    Load = 1'b1;
    D    = v;
    tick();
    Load = 1'b0;
    check("load_data", Data_Out, exp_q.pop_front());
    ref_data = v;
  endtask

  task automatic step_en(input logic [1:0] m, input logic si);
    logic [WIDTH-1:0] e;
    e = model_shift(ref_data, m, si);
    exp_q.push_back(e);
    Shift_En = 1'b1;
    Mode     = m;
    Shift_In = si;
    tick();
    Shift_En = 1'b0;
    check("en_data", Data_Out, exp_q.pop_front());
    check("en_busy", Busy, 1'b0);
    ref_data = e;
  endtask

  // Shift_In follows pat[j] for the j-th shift of the sequence.
  task automatic run_seq(input string tag, input logic [1:0] m, input int k,
                         input logic [31:0] pat, input bit with_en);
    logic [WIDTH-1:0] e;
    int busy_n;
    int done_at;
    e = ref_data;
    for (int j = 0; j < k; j++) e = model_shift(e, m, pat[j % 32]);
    exp_q.push_back(e);
    Start    = 1'b1;
    Mode     = m;
    Count    = CW'(k);
    Shift_En = with_en;
    tick();
    Start    = 1'b0;
    Shift_En = 1'b0;
    busy_n   = 0;
    done_at  = -1;
    for (int i = 0; i < k + 8; i++) begin
      Shift_In = pat[i % 32];
      if (Busy) busy_n++;
      if (Done) begin
        done_at = i;
        break;
      end
      tick();
    end
    if (done_at < 0) begin
      check({tag, "_done_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check({tag, "_done_latency"}, done_at, k);
      check({tag, "_busy_cycles"}, busy_n, k);
      check({tag, "_data"}, Data_Out, exp_q.pop_front());
      tick();
      check({tag, "_done_pulse"}, Done, 1'b0);
      check({tag, "_idle"}, Busy, 1'b0);
    end
    ref_data = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] e;
    int done_seen;
    Reset = 1'b1; Load = 1'b0; D = '0; Shift_En = 1'b0; Start = 1'b0;
    Count = '0; Mode = 2'd0; Shift_In = 1'b0; ref_data = '0;
    #12;
    check("rst_data", Data_Out, 32'h0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;

    do_load(32'h8000_0001);
    run_seq("arith4", 2'd1, 4, 32'h0, 1'b0);

    do_load(32'h0000_000F);
    run_seq("ror36", 2'd3, 36, 32'h0, 1'b0);

    do_load(32'h0000_0001);
    for (int i = 0; i < 3; i++) step_en(2'd2, 1'b1);
    check("en_final", Data_Out, 32'h0000_000F);

    // Start with Count=0 outranks a simultaneous Shift_En
    run_seq("count0", 2'd2, 0, 32'hFFFF_FFFF, 1'b1);

    do_load(32'hFFFF_0000);
    run_seq("log5_pat", 2'd0, 5, 32'h0000_0016, 1'b0);
    do_load(32'h1357_9BDF);
    run_seq("shl40", 2'd2, 40, $urandom, 1'b0);

    do_load(32'h8000_0000);
    Mode = 2'd2; #1;
    check("sout_shl", Shift_Out, 1'b1);
    Mode = 2'd0; #1;
    check("sout_shr", Shift_Out, 1'b0);

    // Load aborts an in-flight sequence; Start during SHIFT is ignored
    do_load(32'hA5A5_0F0F);
    e = ref_data;
    Start = 1'b1; Mode = 2'd0; Count = CW'(8); Shift_In = 1'b0;
    tick();
    Start = 1'b0;
    tick();
    Start = 1'b1; Count = CW'(2); Mode = 2'd2;
    tick();
    Start = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) e = model_shift(e, 2'd0, 1'b0);
    check("abort_busy", Busy, 1'b1);
    check("abort_mid", Data_Out, e);
    Load = 1'b1; D = 32'h1234_5678;
    tick();
    Load = 1'b0;
    check("abort_data", Data_Out, 32'h1234_5678);
    check("abort_idle", Busy, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);

    // Asynchronous reset mid-sequence
    do_load(32'hDEAD_BEEF);
    Start = 1'b1; Mode = 2'd1; Count = CW'(10);
    tick();
    Start = 1'b0;
    tick();
    #2 Reset = 1'b1;
    #1;
    check("arst_data", Data_Out, 32'h0);
    check("arst_busy", Busy, 1'b0);
    check("arst_done", Done, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) done_seen++;
      tick();
    end
    check("arst_no_done", done_seen, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    do_load(32'h0F0F_00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
